msb_seq_scanner: RTL and testbench

- Serial most-significant-set-bit finder for a WIDTH-bit word.
- Uses one byte-wide MSB encoder, time-shared across the bytes of the word.
- The controller scans from the top byte down, one byte per cycle, and stops at the first non-zero byte.
- Valid/ready handshakes on input and output; sits in front of arithmetic and normalisation logic as the area-cheap alternative to a fully parallel 32-bit encoder.

---
 rtl/msb_pkg.sv | 17 +
 rtl/msb_byte_enc.sv | 18 +
 rtl/msb_seq_scanner.sv | 104 ++++++++++
 tb/tb_msb_seq_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared types and constants for the serial MSB scanner
package msb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the value WIDTH itself (top bit set) is representable.
    function automatic int pos_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/msb_byte_enc.sv
// rtl/msb_byte_enc.sv - combinational 1-based MSB encoder for one byte (0 = zero byte)
import msb_pkg::*;

module msb_byte_enc (
    input  logic [7:0] i_byte,
    output logic [3:0] o_pos
);

    always_comb begin
        o_pos = '0;
        for (int b = 0; b < BYTE_W; b++) begin
            if (i_byte[b]) begin
                o_pos = 4'(b + 1);
            end
        end
    end

endmodule

// File: rtl/msb_seq_scanner.sv
// rtl/msb_seq_scanner.sv - byte-serial MSB finder, top byte first; MSB_CYCLE_CNT_EN adds out_cycles
import msb_pkg::*;

module msb_seq_scanner #(
    parameter int WIDTH  = 32,
    parameter int NBYTES = WIDTH / 8,
    parameter int POS_W  = pos_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_num,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MSB_CYCLE_CNT_EN
    output logic [$clog2(NBYTES):0] out_cycles,
`endif
    output logic [POS_W-1:0] output_pos
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            r_state;
    logic [WIDTH-1:0]  r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [POS_W-1:0]  r_pos;

    logic [BYTE_W-1:0] w_bytes [NBYTES];
    logic [BYTE_W-1:0] w_byte;
    logic [3:0]        w_enc;
    logic [POS_W-1:0]  w_pos;
    logic              w_stop;

    for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
        assign w_bytes[g] = r_word[g*BYTE_W +: BYTE_W];
    end

    assign w_byte = w_bytes[r_idx];

    msb_byte_enc u_enc (
        .i_byte (w_byte),
        .o_pos  (w_enc)
    );

    // A zero byte at idx 0 yields w_pos = 0, which is exactly the all-zero result.
    assign w_pos  = POS_W'({r_idx, 3'b000}) + POS_W'(w_enc);
    assign w_stop = (w_enc != 4'd0) || (r_idx == '0);

    assign in_ready   = rst_n && (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign output_pos = r_pos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_pos   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word  <= input_num;
                        r_idx   <= IDX_W'(NBYTES - 1);
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_stop) begin
                        r_pos   <= w_pos;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MSB_CYCLE_CNT_EN
    localparam int CNT_W = $clog2(NBYTES) + 1;

    logic [CNT_W-1:0] r_cycles;

    // Bytes examined = NBYTES - idx at the byte where the scan stopped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == SCAN && w_stop) begin
            r_cycles <= CNT_W'(NBYTES) - CNT_W'(r_idx);
        end
    end

    assign out_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_msb_seq_scanner.sv
// tb/tb_msb_seq_scanner.sv - directed self-checking bench for msb_seq_scanner
module tb_msb_seq_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_num;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  output_pos;
`ifdef MSB_CYCLE_CNT_EN
    logic [2:0]  out_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int k;

    always #5 clk = ~clk;

    msb_seq_scanner #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_num  (input_num),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MSB_CYCLE_CNT_EN
        .out_cycles (out_cycles),
`endif
        .output_pos (output_pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accept edge until out_valid; 99 signals a timeout.
    task automatic wait_valid(output int lat);
        lat = 99;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_word(input string tag, input logic [31:0] w, input int exp_k,
                            input logic [5:0] exp_pos, input int exp_cyc);
        int lat;
        input_num = w;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_k));
        check({tag, "_pos"}, 32'(output_pos), 32'(exp_pos));
`ifdef MSB_CYCLE_CNT_EN
        check({tag, "_cyc"}, 32'(out_cycles), 32'(exp_cyc));
`else
        if (exp_cyc < 0) $display("unexpected cycle value");
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_num = '0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pos", 32'(output_pos), 32'd0);
`ifdef MSB_CYCLE_CNT_EN
        check("rst_cyc", 32'(out_cycles), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_word("top",   32'h8000_0000, 1, 6'd32, 1);
        run_word("one",   32'h0000_0001, 4, 6'd1,  4);
        run_word("b2",    32'h0001_0000, 2, 6'd17, 2);
        run_word("zero",  32'h0000_0000, 4, 6'd0,  4);
        run_word("all",   32'hFFFF_FFFF, 1, 6'd32, 1);
        run_word("b0top", 32'h0000_0080, 4, 6'd8,  4);
        run_word("b3bot", 32'h0100_0000, 1, 6'd25, 1);

        // Backpressure: result must hold while out_ready stays low.
        input_num = 32'h0000_8000;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        wait_valid(k);
        check("bp_lat", 32'(k), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pos", 32'(output_pos), 32'd16);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_drop", 32'(out_valid), 32'd0);
        repeat (3) begin
            step();
            check("bp_single", 32'(out_valid), 32'd0);
        end

        // Reset on the second SCAN cycle discards the scan.
        input_num = 32'h0000_00FF;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pos", 32'(output_pos), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("mid_rst_idle", 32'(in_ready), 32'd1);
        step();
        check("mid_rst_quiet", 32'(out_valid), 32'd0);
        run_word("after_rst", 32'h0400_0000, 1, 6'd27, 1);

        // Back-to-back with in_valid held: second word waits for the handshake.
        input_num = 32'h00F0_0000;
        in_valid  = 1'b1;
        step();
        input_num = 32'h0000_0100;
        wait_valid(k);
        check("b2b1_lat", 32'(k), 32'd2);
        check("b2b1_pos", 32'(output_pos), 32'd24);
        step();
        check("b2b1_hold", 32'(output_pos), 32'd24);
        check("b2b1_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_idle", 32'(in_ready), 32'd1);
        check("b2b_drop", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("b2b2_accept", 32'(in_ready), 32'd0);
        wait_valid(k);
        check("b2b2_lat", 32'(k), 32'd3);
        check("b2b2_pos", 32'(output_pos), 32'd9);
`ifdef MSB_CYCLE_CNT_EN
        check("b2b2_cyc", 32'(out_cycles), 32'd3);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b2_drop", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
